bcd_counter: RTL
================

Name: bcd_counter

Overview:
- Multi-digit synchronous BCD up/down counter. It is the stage directly upstream of the BCD-to-7-segment decoder.
- Each 4-bit digit output feeds one decoder instance, so every nibble is always a legal BCD value (0..9).
- Supports count enable, direction, parallel load with validity check, and a cascadable terminal-count output for chaining counters.

Parameters:
- DIGITS, 2, number of BCD digits (legal 1..4); digit 0 is least significant.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; one step per clock while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load request.
- load_val  input  4*DIGITS  value to load, nibble i = digit i.
- bcd  output  4*DIGITS  current count, nibble i = digit i, registered.
- tc  output  1  terminal count, combinational: en & ~load & (up ? all digits 9 : all digits 0).
- load_err  output  1  registered one-cycle pulse: last load was rejected.

Behaviour:
- Reset (asynchronous, immediate): bcd = 0, load_err = 0. tc then follows its equation, so it reads 1 if en=1, up=0 and load=0. Reset overrides all other inputs at any time, including mid-count and during load.
- Priority on each rising edge: load > en > hold.
- Load, valid (every nibble of load_val is 0..9): bcd <= load_val, load_err <= 0.
- Load, invalid (any nibble 10..15): bcd holds its value, load_err <= 1 for exactly one cycle. Count is suppressed that cycle even if en=1.
- load_err returns to 0 on the next edge unless another invalid load occurs.
- Count up, en=1, load=0, up=1:
  - digit 0 increments.
  - digit i increments only when digits 0..i-1 are all 9; those digits wrap 9 -> 0.
  - Full wrap: all 9s -> all 0s, with tc=1 during the cycle before that edge.
- Count down, en=1, load=0, up=0:
  - digit 0 decrements.
  - digit i decrements only when digits 0..i-1 are all 0; those digits wrap 0 -> 9.
  - Full wrap: all 0s -> all 9s, with tc=1 during the cycle before that edge.
- en=0 and load=0: bcd holds; tc=0.
- A direction change takes effect on the same edge; no pipeline or latency beyond one register stage.
- Latency: bcd reflects a load or count on the edge where the request is sampled (1 cycle).
- Never output a nibble > 9 under any input sequence.
- Width arithmetic is per nibble; no binary adder spans digits.
- Cascading: upper counter en = lower counter tc, with identical up and clk.

Optional Feature:
- Macro BCD_COUNTER_PRESCALE_EN.
- When defined:
  - Adds parameter PRESCALE (default 50_000_000) and an internal free-running divider, reset to 0 by reset.
  - The effective count enable becomes en & tick, where tick is high for one clk cycle every PRESCALE cycles.
  - tc uses the effective enable.
  - load is not gated by tick.
- When undefined: no divider; en is used directly; PRESCALE does not exist.

Test Plan:
- Reset, DIGITS=2: assert reset mid-cycle -> bcd=8'h00 immediately without waiting for a clk edge; load_err=0. Release, en=0 for 5 clocks -> bcd stays 8'h00.
- Up count: en=1, up=1 from 8'h00 for 100 clocks.
  - bcd steps 8'h00, 8'h01 ... 8'h09, 8'h10 ... 8'h99, then 8'h00.
  - tc=1 only while bcd=8'h99.
  - No nibble ever exceeds 9.
- Down count: load 8'h10, then en=1, up=0.
  - bcd goes 8'h09, 8'h08 ... 8'h00, then 8'h99.
  - tc=1 only while bcd=8'h00.
- Load validity:
  - load 8'h47 -> bcd=8'h47, load_err=0.
  - load 8'h4A with en=1 -> bcd stays 8'h47, load_err=1 for one cycle, then 0.
- Priority and direction:
  - load=1 with en=1 and load_val=8'h25 -> bcd=8'h25 (no increment); tc=0 during the load cycle even at 8'h99.
  - Toggle up each cycle from 8'h50 -> 8'h51, 8'h50, 8'h51.
- Prescale (with BCD_COUNTER_PRESCALE_EN, PRESCALE=4): en=1, up=1 from 8'h00 -> bcd increments once every 4 clocks; reaches 8'h03 after 12 clocks.

Source files
------------

// File: rtl/bcd_counter.sv
// Multi-digit BCD up/down counter with validated parallel load and cascadable terminal count.
// Optional input prescaler is enabled with macro BCD_COUNTER_PRESCALE_EN.
`timescale 1ns/1ps
module bcd_counter #(
    parameter int DIGITS = 2
`ifdef BCD_COUNTER_PRESCALE_EN
    ,
    parameter int PRESCALE = 50_000_000
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  tc,
    output logic                  load_err
);

    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                load_err_q, load_err_d;
    logic                en_eff;
    logic                load_ok;
    logic                all9, all0;
    logic                chain_up, chain_dn;
    logic [3:0]          dig;

`ifdef BCD_COUNTER_PRESCALE_EN
    localparam int DIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    // Free-running divider; tick on the last count of each PRESCALE-cycle period.
    assign tick  = (div_q == DIV_W'(PRESCALE - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) div_q <= '0;
        else       div_q <= div_d;
    end

    assign en_eff = en & tick;
`else
    assign en_eff = en;
`endif

    always_comb begin
        load_ok = 1'b1;
        all9    = 1'b1;
        all0    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
            if (bcd_q[4*i +: 4] != 4'd9)   all9    = 1'b0;
            if (bcd_q[4*i +: 4] != 4'd0)   all0    = 1'b0;
        end
    end

    // Per-digit ripple: a digit steps only when every lower digit is at its wrap value.
    always_comb begin
        bcd_d      = bcd_q;
        load_err_d = 1'b0;
        chain_up   = 1'b1;
        chain_dn   = 1'b1;
        dig        = 4'd0;
        if (load) begin
            if (load_ok) bcd_d      = load_val;
            else         load_err_d = 1'b1;
        end else if (en_eff) begin
            for (int i = 0; i < DIGITS; i++) begin
                dig = bcd_q[4*i +: 4];
                if (up) begin
                    if (chain_up) bcd_d[4*i +: 4] = (dig >= 4'd9) ? 4'd0 : dig + 4'd1;
                end else begin
                    if (chain_dn) bcd_d[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
                end
                chain_up = chain_up & (dig == 4'd9);
                chain_dn = chain_dn & (dig == 4'd0);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            bcd_q      <= bcd_d;
            load_err_q <= load_err_d;
        end
    end

    assign bcd      = bcd_q;
    assign load_err = load_err_q;
    assign tc       = en_eff & ~load & (up ? all9 : all0);

endmodule
